// File: rtl/half_exp_seq.sv
// half_exp_seq: streams a WIDTH-element FP16 vector through a LANES-wide exp array
// and reassembles the results in order, trading area for BEATS issue cycles.
module half_exp_seq #(
  parameter int WIDTH = 10,
  parameter int LANES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0][15:0]  vector_a,
  output logic                    exp_valid,
  output logic [LANES-1:0][15:0]  exp_a,
  input  logic                    exp_out_valid,
  input  logic [LANES-1:0][15:0]  exp_c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0][15:0]  vector_c,
  output logic                    err
);
  localparam int BEATS = (WIDTH + LANES - 1) / LANES;
  localparam int CW = $clog2(BEATS + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          issue_cnt_q, issue_cnt_d, ret_cnt_q, ret_cnt_d;
  logic [WIDTH-1:0][15:0] in_buf_q, in_buf_d, out_buf_q, out_buf_d, vector_c_q, vector_c_d;
  logic                   err_q, err_d, ret_ok, last_ret;
  assign in_ready  = state_q == IDLE;
  assign exp_valid = state_q == ISSUE;
  assign out_valid = state_q == DONE;
  assign vector_c  = vector_c_q;
  assign err       = err_q;
  always_comb begin
    ret_ok      = exp_out_valid && (state_q == ISSUE || state_q == WAIT) && ret_cnt_q < CW'(BEATS);
    last_ret    = ret_cnt_q + CW'(ret_ok) == CW'(BEATS);
    ret_cnt_d   = state_q == DONE && out_ready ? '0 : ret_cnt_q + CW'(ret_ok);
    err_d       = err_q | (exp_out_valid & ~ret_ok);
    issue_cnt_d = state_q == ISSUE ? issue_cnt_q + CW'(1) : '0;
    in_buf_d    = in_ready && in_valid ? vector_a : in_buf_q;
    out_buf_d   = out_buf_q;
    exp_a       = '0;
    // lanes past WIDTH keep their zero default on issue and are dropped on return
    for (int w = 0; w < WIDTH; w++) begin
      if (ret_ok && ret_cnt_q == CW'(w / LANES)) out_buf_d[w] = exp_c[w % LANES];
      if (state_q == ISSUE && issue_cnt_q == CW'(w / LANES)) exp_a[w % LANES] = in_buf_q[w];
    end
    state_d = state_q == IDLE  ? (in_valid ? ISSUE : IDLE)
            : state_q == ISSUE ? (issue_cnt_q == CW'(BEATS - 1) ? (last_ret ? DONE : WAIT) : ISSUE)
            : state_q == WAIT  ? (last_ret ? DONE : WAIT)
            : (out_ready ? IDLE : DONE);
    vector_c_d = state_d == DONE && state_q != DONE ? out_buf_d : vector_c_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      in_buf_q    <= '0;
      out_buf_q   <= '0;
      vector_c_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      in_buf_q    <= in_buf_d;
      out_buf_q   <= out_buf_d;
      vector_c_q  <= vector_c_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_half_exp_seq.sv
// tb_half_exp_seq: directed checks of half_exp_seq (10x2 and 5x2) against a
// three-cycle mock exp array that maps 0->1.0, 1.0->e and scrambles other values.
module tb_half_exp_seq;
  logic clk = 1'b0, rstn = 1'b0, force_ov = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic a_iv = 1'b0, a_ir, a_ev, a_eov, a_ov, a_or = 1'b1, a_err;
  logic [9:0][15:0] a_va = '0, a_vc, v1, v2, v3;
  logic [1:0][15:0] a_ea, a_ec;
  logic b_iv = 1'b0, b_ir, b_ev, b_eov, b_ov, b_err;
  logic [4:0][15:0] b_va = '0, b_vc, bexp;
  logic [1:0][15:0] b_ea, b_ec;
  logic [2:0] a_pv, b_pv;
  logic [2:0][1:0][15:0] a_pd, b_pd;
  int evc, n;

  half_exp_seq #(.WIDTH(10), .LANES(2)) dut (
    .clk(clk), .rstn(rstn), .in_valid(a_iv), .in_ready(a_ir), .vector_a(a_va),
    .exp_valid(a_ev), .exp_a(a_ea), .exp_out_valid(a_eov), .exp_c(a_ec),
    .out_valid(a_ov), .out_ready(a_or), .vector_c(a_vc), .err(a_err));
  half_exp_seq #(.WIDTH(5), .LANES(2)) dut5 (
    .clk(clk), .rstn(rstn), .in_valid(b_iv), .in_ready(b_ir), .vector_a(b_va),
    .exp_valid(b_ev), .exp_a(b_ea), .exp_out_valid(b_eov), .exp_c(b_ec),
    .out_valid(b_ov), .out_ready(1'b1), .vector_c(b_vc), .err(b_err));

  function automatic logic [15:0] fx(input logic [15:0] x);
    return x == 16'h0000 ? 16'h3C00 : x == 16'h3C00 ? 16'h4170 : x ^ 16'h5A5A;
  endfunction

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      a_pv <= '0; a_pd <= '0; b_pv <= '0; b_pd <= '0;
    end else begin
      a_pv <= {a_pv[1:0], a_ev};
      a_pd <= {a_pd[1:0], fx(a_ea[1]), fx(a_ea[0])};
      b_pv <= {b_pv[1:0], b_ev};
      b_pd <= {b_pd[1:0], fx(b_ea[1]), fx(b_ea[0])};
    end
  assign a_eov = a_pv[2] | force_ov;
  assign a_ec  = a_pd[2];
  assign b_eov = b_pv[2];
  assign b_ec  = b_pd[2];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0][15:0] model(input logic [9:0][15:0] v);
    for (int i = 0; i < 10; i++) model[i] = fx(v[i]);
  endfunction

  // accept v at the current cycle, check each beat's operands, stop at out_valid
  task automatic run_a(input logic [9:0][15:0] v);
    a_iv = 1'b1; a_va = v;
    tick;
    a_iv = 1'b0;
    evc = 0; n = 0;
    while (!a_ov && n < 30) begin
      if (a_ev) chk("beat_operands", 160'(a_ea), 160'({v[2*evc+1], v[2*evc]}));
      evc += int'(a_ev);
      tick;
      n++;
    end
    chk("out_valid_reached", 160'(a_ov), 160'(1));
    chk("exp_valid_cycles", 160'(evc), 160'(5));
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      v1[i] = 16'h3C00;
      v2[i] = 16'h1000 + 16'(i) * 16'h0111;
      v3[i] = 16'h2200 + 16'(i) * 16'h0013;
    end
    #12;
    chk("rst_in_ready", 160'(a_ir), 160'(1));
    chk("rst_outputs", 160'({a_ev, a_ov, a_err, a_ea}), 160'(0));
    chk("rst_vector_c", 160'(a_vc), 160'(0));
    @(negedge clk) rstn = 1'b1;
    tick;
    // zero vector, exact cycle timing with L=3
    a_iv = 1'b1; a_va = '0;
    for (int c = 1; c <= 11; c++) begin
      tick;
      a_iv = 1'b0;
      chk($sformatf("t_exp_valid_c%0d", c), 160'(a_ev), 160'(c <= 5));
      chk($sformatf("t_out_valid_c%0d", c), 160'(a_ov), 160'(c == 9));
      chk($sformatf("t_in_ready_c%0d", c), 160'(a_ir), 160'(c >= 10));
      if (c == 9) chk("zero_result", 160'(a_vc), 160'({10{16'h3C00}}));
    end
    chk("zero_err", 160'(a_err), 160'(0));
    // all-ones input gives e everywhere
    run_a(v1);
    chk("one_result", 160'(a_vc), 160'({10{16'h4170}}));
    tick;
    // distinct values land at their own indices
    run_a(v2);
    chk("distinct_result", 160'(a_vc), 160'(model(v2)));
    tick;
    chk("hold_after_hs", 160'(a_vc), 160'(model(v2)));
    // WIDTH=5: three beats, last beat padded
    for (int i = 0; i < 5; i++) b_va[i] = 16'h4400 + 16'(i) * 16'h0101;
    for (int i = 0; i < 5; i++) bexp[i] = fx(b_va[i]);
    b_iv = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick;
      b_iv = 1'b0;
      chk($sformatf("w5_exp_valid_c%0d", c), 160'(b_ev), 160'(c <= 3));
      chk($sformatf("w5_out_valid_c%0d", c), 160'(b_ov), 160'(c == 7));
      if (c == 3) chk("w5_pad_beat", 160'(b_ea), 160'({16'h0000, b_va[4]}));
    end
    chk("w5_result", 160'(b_vc), 160'(bexp));
    chk("w5_err", 160'(b_err), 160'(0));
    tick;
    // backpressure in DONE
    a_or = 1'b0;
    run_a(v3);
    for (int c = 0; c < 4; c++) begin
      a_iv = c[0];
      tick;
      chk("bp_out_valid", 160'(a_ov), 160'(1));
      chk("bp_in_ready", 160'(a_ir), 160'(0));
      chk("bp_vector_c", 160'(a_vc), 160'(model(v3)));
    end
    a_iv = 1'b0; a_or = 1'b1;
    tick;
    chk("bp_release", 160'({a_ir, a_ov}), 160'(2'b10));
    tick;
    chk("bp_no_accept", 160'(a_ev), 160'(0));
    // reset during beat 2
    a_iv = 1'b1; a_va = v2;
    tick;
    a_iv = 1'b0;
    tick;
    tick;
    chk("pre_reset_issue", 160'(a_ev), 160'(1));
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_ctrl", 160'({a_ir, a_ev, a_ov, a_err}), 160'(4'b1000));
    chk("async_rst_data", 160'({a_ea, a_vc}), 160'(0));
    @(negedge clk) rstn = 1'b1;
    tick;
    run_a(v3);
    chk("post_reset_result", 160'(a_vc), 160'(model(v3)));
    tick;
    chk("post_reset_err", 160'(a_err), 160'(0));
    // stray result in IDLE sets sticky err
    force_ov = 1'b1;
    tick;
    force_ov = 1'b0;
    chk("err_set", 160'(a_err), 160'(1));
    tick;
    tick;
    tick;
    chk("err_sticky", 160'({a_err, a_ir, a_ov}), 160'(3'b110));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
